// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for the register-file write port; in: clk, reset_n, req_valid/req_index/req_data, claim_valid/claim_index, rd_a_index/rd_b_index; out: req_ready, rf_write_enable/rf_write_register/rf_write_data, wb_grant, rd_a_busy/rd_b_busy; REGFILE_WB_SCOREBOARD_EN builds the pending-write scoreboard
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [5*NUM_REQ-1:0]  req_index,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic                  rf_write_enable,
  output logic [4:0]            rf_write_register,
  output logic [31:0]           rf_write_data,
  output logic [NUM_REQ-1:0]    wb_grant,
  input  logic                  claim_valid,
  input  logic [4:0]            claim_index,
  input  logic [4:0]            rd_a_index,
  input  logic [4:0]            rd_b_index,
  output logic                  rd_a_busy,
  output logic                  rd_b_busy
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] ptr_q, ptr_d, g, idx;
  logic hs;
  logic [4:0] ri [NUM_REQ];
  logic [31:0] rd [NUM_REQ];
  logic we_q, we_d;
  logic [4:0] reg_q, reg_d;
  logic [31:0] data_q, data_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign ri[i] = req_index[5*i +: 5];
    assign rd[i] = req_data[32*i +: 32];
  end
  always_comb begin
    req_ready = '0;
    g = '0;
    hs = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (!hs && req_valid[idx]) begin
        hs = 1'b1;
        g = idx;
        req_ready[idx] = 1'b1;
      end
    end
  end
  always_comb begin
    ptr_d = hs ? ((int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1) : ptr_q;
    we_d = hs && (ri[g] != 5'd0);
    reg_d = hs ? ri[g] : reg_q;
    data_d = hs ? rd[g] : data_q;
    grant_d = req_ready;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      we_q <= 1'b0;
      reg_q <= '0;
      data_q <= '0;
      grant_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      we_q <= we_d;
      reg_q <= reg_d;
      data_q <= data_d;
      grant_q <= grant_d;
    end
  end
  assign rf_write_enable = we_q;
  assign rf_write_register = reg_q;
  assign rf_write_data = data_q;
  assign wb_grant = grant_q;
`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [31:0] pend_q, pend_d;
  always_comb begin
    pend_d = pend_q & ~({31'd0, we_q} << reg_q);
    pend_d = pend_d | ({31'd0, claim_valid} << claim_index);
    pend_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend_q <= '0;
    else pend_q <= pend_d;
  end
  assign rd_a_busy = pend_q[rd_a_index];
  assign rd_b_busy = pend_q[rd_b_index];
`else
  logic unused_scoreboard;
  assign unused_scoreboard = ^{claim_valid, claim_index, rd_a_index, rd_b_index};
  assign rd_a_busy = 1'b0;
  assign rd_b_busy = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: random + directed scoreboard bench for regfile_write_arbiter against a behavioural model
module tb_regfile_write_arbiter;
  localparam int N = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, wb_grant;
  logic [5*N-1:0] req_index;
  logic [32*N-1:0] req_data;
  logic rf_write_enable, claim_valid, rd_a_busy, rd_b_busy;
  logic [4:0] rf_write_register, claim_index, rd_a_index, rd_b_index;
  logic [31:0] rf_write_data;
  always #5 clk = ~clk;
  regfile_write_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_data(req_data),
    .rf_write_enable(rf_write_enable), .rf_write_register(rf_write_register),
    .rf_write_data(rf_write_data), .wb_grant(wb_grant),
    .claim_valid(claim_valid), .claim_index(claim_index),
    .rd_a_index(rd_a_index), .rd_b_index(rd_b_index),
    .rd_a_busy(rd_a_busy), .rd_b_busy(rd_b_busy)
  );
  typedef struct {int cyc; logic we; logic [4:0] r; logic [31:0] d; logic [N-1:0] g;} out_t;
  typedef struct {logic [N-1:0] rdy; logic ba; logic bb;} rdy_t;
  out_t out_q[$];
  rdy_t rdy_q[$];
  int n_vec = 0, n_err = 0, cnt = 0;
  bit chk_en = 0;
  int m_ptr, last_g;
  logic m_we;
  logic [4:0] m_reg;
  logic [31:0] m_data;
  bit m_pend [32];
  always @(posedge clk) cnt <= cnt + 1;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
    end
  endtask
  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_reg = 0; m_data = 0; last_g = -1;
    foreach (m_pend[i]) m_pend[i] = 0;
  endtask
  task automatic step(input logic [N-1:0] v, input logic [5*N-1:0] ix, input logic [32*N-1:0] d,
                      input bit cv, input logic [4:0] ci, input logic [4:0] ra, input logic [4:0] rb);
    rdy_t r;
    out_t o;
    int g;
    req_valid = v; req_index = ix; req_data = d;
    claim_valid = cv; claim_index = ci; rd_a_index = ra; rd_b_index = rb;
`ifdef REGFILE_WB_SCOREBOARD_EN
    r.ba = m_pend[ra]; r.bb = m_pend[rb];
`else
    r.ba = 0; r.bb = 0;
`endif
    if (m_we) m_pend[m_reg] = 0;
    if (cv && ci != 0) m_pend[ci] = 1;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    r.rdy = '0;
    if (g >= 0) begin
      r.rdy[g] = 1'b1;
      m_reg = ix[5*g +: 5];
      m_we = m_reg != 0;
      m_data = d[32*g +: 32];
      m_ptr = (g + 1) % N;
    end else m_we = 0;
    o.cyc = cnt + 1; o.we = m_we; o.r = m_reg; o.d = m_data; o.g = r.rdy;
    rdy_q.push_back(r);
    out_q.push_back(o);
    last_g = g;
    @(posedge clk);
    #1;
  endtask
  rdy_t mr;
  out_t mo;
  always @(negedge clk) if (chk_en) begin
    if (rdy_q.size() > 0) begin
      mr = rdy_q.pop_front();
      chk("req_ready", req_ready, mr.rdy);
      chk("rd_a_busy", rd_a_busy, mr.ba);
      chk("rd_b_busy", rd_b_busy, mr.bb);
    end
    while (out_q.size() > 0 && out_q[0].cyc <= cnt) begin
      mo = out_q.pop_front();
      if (mo.cyc < cnt) begin
        n_vec++; n_err++;
        $display("FAIL stale_output: cycle %0d expectation unchecked at cycle %0d", mo.cyc, cnt);
      end else begin
        chk("rf_write_enable", rf_write_enable, mo.we);
        chk("rf_write_register", rf_write_register, mo.r);
        chk("rf_write_data", rf_write_data, mo.d);
        chk("wb_grant", wb_grant, mo.g);
      end
    end
  end
  task automatic do_reset();
    chk_en = 0;
    req_valid = 0; req_index = 0; req_data = 0;
    claim_valid = 0; claim_index = 0; rd_a_index = 5'd9; rd_b_index = 5'd8;
    #1 reset_n = 0;
    #1;
    chk("rst_we", rf_write_enable, 0);
    chk("rst_reg", rf_write_register, 0);
    chk("rst_data", rf_write_data, 0);
    chk("rst_grant", wb_grant, 0);
    chk("rst_busy_a", rd_a_busy, 0);
    chk("rst_busy_b", rd_b_busy, 0);
    out_q.delete();
    rdy_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_busy_a", rd_a_busy, 0);
    chk("post_rst_busy_b", rd_b_busy, 0);
    chk_en = 1;
  endtask
  initial begin
    logic [N-1:0] hv;
    logic [5*N-1:0] hi;
    logic [32*N-1:0] hd;
    req_valid = 0; req_index = 0; req_data = 0;
    claim_valid = 0; claim_index = 0; rd_a_index = 0; rd_b_index = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    repeat (6) step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 0, 0, 0, 0);
    step(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEADBEEF, 32'd0}, 0, 0, 0, 0);
    step(3'b001, {5'd0, 5'd0, 5'd0}, {64'd0, 32'h1234}, 0, 0, 0, 0);
    step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 0, 0, 0, 0);
    step(3'b000, 0, 0, 1, 5'd8, 5'd8, 5'd0);
    step(3'b000, 0, 0, 0, 5'd0, 5'd8, 5'd8);
    step(3'b010, {5'd0, 5'd8, 5'd0}, {32'd0, 32'h88, 32'd0}, 0, 0, 5'd8, 5'd8);
    step(3'b000, 0, 0, 0, 5'd0, 5'd8, 5'd8);
    step(3'b000, 0, 0, 0, 5'd0, 5'd8, 5'd8);
    step(3'b000, 0, 0, 1, 5'd9, 5'd9, 5'd8);
    step(3'b100, {5'd9, 10'd0}, {32'h99, 64'd0}, 0, 0, 5'd9, 5'd9);
    step(3'b000, 0, 0, 1, 5'd9, 5'd9, 5'd9);
    step(3'b000, 0, 0, 0, 5'd0, 5'd9, 5'd9);
    step(3'b000, 0, 0, 0, 5'd0, 5'd9, 5'd9);
    step(3'b001, {10'd0, 5'd7}, {64'd0, 32'h77}, 0, 0, 5'd9, 5'd9);
    chk("pre_rst_we", rf_write_enable, m_we);
    do_reset();
    repeat (3) step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA}, 0, 0, 0, 0);
    hv = 0; hi = 0; hd = 0;
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) if (!hv[i] && $urandom_range(0, 1) == 1) begin
        hv[i] = 1'b1;
        hi[5*i +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        hd[32*i +: 32] = $urandom;
      end
      step(hv, hi, hd, $urandom_range(0, 2) == 0, 5'($urandom), 5'($urandom), 5'($urandom));
      if (last_g >= 0) hv[last_g] = 1'b0;
    end
    repeat (2) step(3'b000, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 10 && (out_q.size() > 0 || rdy_q.size() > 0); i++) @(negedge clk);
    if (out_q.size() > 0 || rdy_q.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d outputs and %0d grants still expected, 0 required", out_q.size(), rdy_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
